// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and FSM state encoding shared by the execute unit.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/result valid-ready bus between issue logic (master) and the ALU (slave).
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_alu_control;
  logic [WIDTH-1:0] in_src_a;
  logic [WIDTH-1:0] in_src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             busy;
  modport master (
    output in_valid, in_alu_control, in_src_a, in_src_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, busy
  );
  modport slave (
    input  in_valid, in_alu_control, in_src_a, in_src_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, busy
  );
endinterface

// File: rtl/alu_shift_serial.sv
// alu_shift_serial: one-bit-per-cycle shifter; counts the loaded amount down to zero.
module alu_shift_serial #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_load,
  input  logic                     i_right,
  input  logic                     i_arith,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_amt,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_done
);
  logic [WIDTH-1:0]         r_data;
  logic [$clog2(WIDTH)-1:0] r_cnt;
  logic                     r_right, r_arith;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_cnt   <= i_amt;
      r_right <= i_right;
      r_arith <= i_arith;
    end else if (r_cnt != '0) begin
      r_data <= r_right ? {r_arith & r_data[WIDTH-1], r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], 1'b0};
      r_cnt  <= r_cnt - 1'b1;
    end
  assign o_data = r_data;
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready execute-stage ALU with a registered result and zero flag.
// Define ALU_SHIFT_EN to add bit-serial sll/srl/sra that stall the input while shifting.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            resetn,
  alu_exec_unit_if.slave bus
);
  state_t           r_state;
  logic             r_valid, r_zero;
  logic [WIDTH-1:0] r_result, w_alu, w_next, w_a, w_b;
  logic [2:0]       w_code;
  logic             w_slot, w_accept, w_start, w_finish;
  assign w_code       = bus.in_alu_control;
  assign w_a          = bus.in_src_a;
  assign w_b          = bus.in_src_b;
  assign w_slot       = !r_valid || bus.out_ready;
  assign bus.in_ready = (r_state == IDLE) && w_slot;
  assign w_accept     = bus.in_valid && bus.in_ready;
`ifdef ALU_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
  logic             w_is_shift, w_done;
  logic [WIDTH-1:0] w_shifted;
  assign w_is_shift = w_code[2] && w_code != ALU_SLT;
  assign w_start    = w_accept && w_is_shift && w_b[SW-1:0] != '0;
  assign w_finish   = (r_state == SHIFT) && w_done && w_slot;
  assign w_next     = w_finish ? w_shifted : w_alu;
  assign bus.busy   = r_state == SHIFT;
  alu_shift_serial #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_start),
    .i_right (w_code[1]),
    .i_arith (w_code[1] & w_code[0]),
    .i_data  (w_a),
    .i_amt   (w_b[SW-1:0]),
    .o_data  (w_shifted),
    .o_done  (w_done)
  );
`else
  assign w_start  = 1'b0;
  assign w_finish = 1'b0;
  assign w_next   = w_alu;
  assign bus.busy = 1'b0;
`endif
  always_comb begin
    w_alu = w_code == ALU_ADD ? w_a + w_b :
            w_code == ALU_SUB ? w_a - w_b :
            w_code == ALU_AND ? w_a & w_b :
            w_code == ALU_OR  ? w_a | w_b :
            w_code == ALU_SLT ? WIDTH'($signed(w_a) < $signed(w_b)) : '0;
`ifdef ALU_SHIFT_EN
    // a zero-amount shift bypasses the serial path and returns operand A
    if (w_is_shift) w_alu = w_a;
`endif
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_slot) r_valid <= 1'b0;
      if ((w_accept && !w_start) || w_finish) begin
        r_valid  <= 1'b1;
        r_result <= w_next;
        r_zero   <= w_next == '0;
      end
      r_state <= w_start ? SHIFT : w_finish ? IDLE : r_state;
    end
  assign bus.out_valid  = r_valid;
  assign bus.out_result = r_result;
  assign bus.out_zero   = r_zero;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random stimulus against a cycle-level reference of the ALU's transfer rules.
module tb_alu_exec_unit;
  import alu_pkg::*;
  localparam int W = 32;
`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int n_checks = 0;
  int n_errors = 0;
  bit m_ovalid = 1'b0;
  bit m_fire = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_shval = '0;
  int m_cnt = -1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    case (c)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'b100: return SHIFT_EN ? a << sh : '0;
      3'b110: return SHIFT_EN ? a >> sh : '0;
      3'b111: return SHIFT_EN ? W'($signed(a) >>> sh) : '0;
      default: return '0;
    endcase
  endfunction
  function automatic bit serial(input logic [2:0] c, input logic [W-1:0] b);
    return SHIFT_EN && c[2] && c != 3'b101 && (b % W) != 0;
  endfunction
  task automatic step(input logic v, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    bit slot, rdy;
    bus.in_valid = v;
    bus.in_alu_control = c;
    bus.in_src_a = a;
    bus.in_src_b = b;
    bus.out_ready = ordy;
    #1;
    slot = !m_ovalid || ordy;
    rdy = (m_cnt < 0) && slot;
    check("in_ready", bus.in_ready, rdy);
    m_fire = v && rdy;
    @(posedge clk);
    if (slot) m_ovalid = 1'b0;
    if (m_cnt == 0 && slot) begin
      m_ovalid = 1'b1;
      m_res = m_shval;
      m_cnt = -1;
    end else if (m_cnt > 0) m_cnt--;
    if (m_fire) begin
      if (serial(c, b)) begin
        m_cnt = int'(b % W);
        m_shval = ref_op(c, a, b);
      end else begin
        m_ovalid = 1'b1;
        m_res = ref_op(c, a, b);
      end
    end
    @(negedge clk);
    check("out_valid", bus.out_valid, m_ovalid);
    check("busy", bus.busy, m_cnt >= 0);
    if (m_ovalid) begin
      check("result", bus.out_result, m_res);
      check("zero", bus.out_zero, m_res == '0);
    end
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction
  initial begin
    int acc, n_busy;
    bus.in_valid = 1'b0;
    bus.in_alu_control = '0;
    bus.in_src_a = '0;
    bus.in_src_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_zero", bus.out_zero, 0);
    resetn = 1'b1;
    step(1, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1);
    check("add_wrap", bus.out_result, 32'h8000_0000);
    check("add_wrap_zero", bus.out_zero, 0);
    step(1, ALU_SUB, 32'd5, 32'd5, 1);
    check("sub_zero_res", bus.out_result, 0);
    check("sub_zero_flag", bus.out_zero, 1);
    step(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1);
    check("slt_neg", bus.out_result, 1);
    step(1, ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1);
    check("slt_pos", bus.out_result, 0);
    step(1, ALU_AND, 32'hF0F0, 32'h0FF0, 1);
    check("and", bus.out_result, 32'h00F0);
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      step(1, ALU_ADD, W'(acc * 16 + 1), W'(acc), !(cyc >= 3 && cyc <= 5));
      if (m_fire) acc++;
    end
    check("b2b_count", acc, 8);
    step(0, ALU_ADD, 0, 0, 1);
`ifdef ALU_SHIFT_EN
    step(1, ALU_SRA, 32'h8000_0000, 32'd4, 1);
    n_busy = 0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      if (bus.busy) n_busy++;
      step(0, ALU_ADD, 0, 0, 1);
    end
    check("sra_busy_cycles", n_busy, 5);
    check("sra_result", bus.out_result, 32'hF800_0000);
    step(1, ALU_SLL, 32'hABCD, 32'h20, 1);
    check("sll0_result", bus.out_result, 32'hABCD);
    step(1, ALU_SRL, 32'hF0, 32'd4, 1);
    step(0, ALU_ADD, 0, 0, 1);
    step(0, ALU_ADD, 0, 0, 1);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_result", bus.out_result, 0);
    m_ovalid = 1'b0;
    m_cnt = -1;
    m_res = '0;
    @(negedge clk);
    resetn = 1'b1;
    step(1, ALU_ADD, 32'd2, 32'd3, 1);
    check("post_rst_add", bus.out_result, 32'd5);
`else
    step(1, ALU_SLL, 32'h1234, 32'd3, 1);
    check("noshift_valid", bus.out_valid, 1);
    check("noshift_result", bus.out_result, 0);
    check("noshift_zero", bus.out_zero, 1);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
